fifo_rd_packer: RTL and testbench

Read-side drain stage placed directly downstream of the async FIFO read port, in the read clock domain. It pops DSIZE-bit entries from the FIFO's first-word-fall-through interface (rdata, rempty, rinc) and packs LANES consecutive entries into one wide word on a valid/ready output stream. An optional idle timeout flushes partially filled words with a lane-keep mask.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_idle_timer.sv | 41 ++++
 rtl/fifo_rd_packer.sv | 104 ++++++++++
 tb/tb_fifo_rd_packer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
// Holds the default geometry, the counter width helper and the lane-keep mask builder.
package fifo_pkg;

   localparam int DEF_DSIZE   = 8;
   localparam int DEF_LANES   = 4;
   localparam int DEF_TIMEOUT = 16;

   // Bits needed to hold any value in 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic [31:0] keep_mask(input int unsigned cnt);
      return (32'd1 << cnt) - 32'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Idle counter for the read packer: requests a flush of a partial word after TIMEOUT quiet edges.
// Only instantiated when FIFO_RD_PACK_TIMEOUT_EN is defined.
module fifo_rd_idle_timer
   import fifo_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic rclk,
   input  logic rrst,
   input  logic pop,
   input  logic cnt_zero,
   input  logic out_free,
   output logic flush
);

   localparam int IW = cnt_width(TIMEOUT);

   logic [IW-1:0] idle_q;
   logic [IW-1:0] idle_d;

   assign flush = (idle_q == IW'(TIMEOUT)) && !cnt_zero && out_free;

   // Saturates at TIMEOUT so a flush blocked by backpressure fires as soon as the output frees.
   always_comb begin
      idle_d = idle_q;
      if (pop || cnt_zero || flush) begin
         idle_d = '0;
      end else if (idle_q != IW'(TIMEOUT)) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs LANES entries per output word on a valid/ready stream.
// Define FIFO_RD_PACK_TIMEOUT_EN to flush partial words with a keep mask after TIMEOUT idle cycles.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DSIZE   = DEF_DSIZE,
   parameter int LANES   = DEF_LANES,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   rclk,
   input  logic                   rrst,
   input  logic [DSIZE-1:0]       rdata,
   input  logic                   rempty,
   output logic                   rinc,
   output logic [DSIZE*LANES-1:0] m_data,
   output logic [LANES-1:0]       m_keep,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   busy
);

   localparam int CW = cnt_width(LANES - 1);
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   logic [DSIZE*LANES-1:0] acc_q, acc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DSIZE*LANES-1:0] m_data_q, m_data_d;
   logic [LANES-1:0]       m_keep_q, m_keep_d;
   logic                   m_valid_q, m_valid_d;
   logic                   out_free;
   logic                   flush;

   assign out_free = !m_valid_q || m_ready;
   assign rinc     = !rrst && !rempty && !flush && ((cnt_q != LAST) || out_free);
   assign busy     = (cnt_q != '0) || m_valid_q;
   assign m_data   = m_data_q;
   assign m_keep   = m_keep_q;
   assign m_valid  = m_valid_q;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
   fifo_rd_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .rclk     (rclk),
      .rrst     (rrst),
      .pop      (rinc),
      .cnt_zero (cnt_q == '0),
      .out_free (out_free),
      .flush    (flush)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT < 1);
   assign flush = 1'b0;
`endif

   // A load at the same edge as a transfer wins, so the output never bubbles at a word boundary.
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_valid_d = m_valid_q;
      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
      if (flush) begin
         m_data_d  = acc_q;
         m_keep_d  = LANES'(keep_mask(32'(cnt_q)));
         m_valid_d = 1'b1;
         cnt_d     = '0;
         acc_d     = '0;
      end else if (rinc) begin
         if (cnt_q == LAST) begin
            m_data_d                           = acc_q;
            m_data_d[(LANES-1)*DSIZE +: DSIZE] = rdata;
            m_keep_d                           = '1;
            m_valid_d                          = 1'b1;
            cnt_d                              = '0;
            acc_d                              = '0;
         end else begin
            acc_d[int'(cnt_q)*DSIZE +: DSIZE] = rdata;
            cnt_d                             = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_valid_q <= m_valid_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based reference model plus directed literal checks.
// Honours FIFO_RD_PACK_TIMEOUT_EN the same way the design does.
module tb_fifo_rd_packer;

   localparam int DSIZE   = 8;
   localparam int LANES   = 4;
   localparam int TIMEOUT = 16;
   localparam int WW      = DSIZE * LANES;

   logic             rclk = 1'b0;
   logic             rrst = 1'b1;
   logic [DSIZE-1:0] rdata = '0;
   logic             rempty = 1'b1;
   logic             rinc;
   logic [WW-1:0]    m_data;
   logic [LANES-1:0] m_keep;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic             busy;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [DSIZE-1:0] src_q[$];
   logic [DSIZE-1:0] mdl_acc[$];
   logic             mdl_valid = 1'b0;
   logic [WW-1:0]    mdl_data = '0;
   logic [LANES-1:0] mdl_keep = '0;
   int               mdl_idle = 0;

   logic [WW-1:0]    word_log[$];
   logic [LANES-1:0] keep_log[$];
   int               cyc_log[$];

   fifo_rd_packer #(
      .DSIZE   (DSIZE),
      .LANES   (LANES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rdata   (rdata),
      .rempty  (rempty),
      .rinc    (rinc),
      .m_data  (m_data),
      .m_keep  (m_keep),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .busy    (busy)
   );

   always #5 rclk = ~rclk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WW-1:0] pack_entries(input logic [DSIZE-1:0] q[$]);
      logic [WW-1:0] w;
      w = '0;
      foreach (q[i]) w[i*DSIZE +: DSIZE] = q[i];
      return w;
   endfunction

   function automatic logic mdl_flush();
`ifdef FIFO_RD_PACK_TIMEOUT_EN
      return (mdl_idle == TIMEOUT) && (mdl_acc.size() > 0) && (!mdl_valid || m_ready);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic mdl_rinc();
      return !rrst && !rempty && !mdl_flush() &&
             ((mdl_acc.size() < LANES - 1) || !mdl_valid || m_ready);
   endfunction

   task automatic mdl_reset();
      mdl_acc.delete();
      mdl_valid = 1'b0;
      mdl_data  = '0;
      mdl_keep  = '0;
      mdl_idle  = 0;
   endtask

   // Reference model: entries gather in a queue; LANES of them, or a timeout, make a word.
   always @(posedge rclk) begin
      logic pop;
      logic fl;
      int   n_before;
      if (!rrst) begin
         fl       = mdl_flush();
         pop      = mdl_rinc();
         n_before = mdl_acc.size();
         if (mdl_valid && m_ready) mdl_valid = 1'b0;
         if (fl) begin
            mdl_data  = pack_entries(mdl_acc);
            mdl_keep  = '0;
            for (int i = 0; i < n_before; i++) mdl_keep[i] = 1'b1;
            mdl_valid = 1'b1;
            mdl_acc.delete();
         end else if (pop) begin
            mdl_acc.push_back(rdata);
            void'(src_q.pop_front());
            if (mdl_acc.size() == LANES) begin
               mdl_data  = pack_entries(mdl_acc);
               mdl_keep  = '1;
               mdl_valid = 1'b1;
               mdl_acc.delete();
            end
         end
         if (pop || fl || n_before == 0) mdl_idle = 0;
         else if (mdl_idle < TIMEOUT) mdl_idle++;
      end
   end

   // Per-cycle comparison against the model, plus a log of every word the DUT hands over.
   always begin
      @(negedge rclk);
      #1;
      cyc++;
      checkOutput("rinc", rinc, mdl_rinc());
      checkOutput("m_valid", m_valid, mdl_valid);
      checkOutput("busy", busy, (mdl_acc.size() > 0) || mdl_valid);
      if (mdl_valid) begin
         checkOutput("m_data", m_data, mdl_data);
         checkOutput("m_keep", m_keep, mdl_keep);
      end
      if (m_valid && m_ready) begin
         word_log.push_back(m_data);
         keep_log.push_back(m_keep);
         cyc_log.push_back(cyc);
      end
   end

   task automatic applyStimulus(input logic ready, input logic gate_empty);
      @(negedge rclk);
      m_ready = ready;
      rempty  = gate_empty || (src_q.size() == 0);
      rdata   = (src_q.size() != 0) ? src_q[0] : '0;
      #2;
   endtask

   task automatic clear_logs();
      word_log.delete();
      keep_log.delete();
      cyc_log.delete();
   endtask

   initial begin
      int n;
      // Reset held with data waiting.
      for (int i = 1; i <= 8; i++) src_q.push_back(DSIZE'(i * 17));
      repeat (3) applyStimulus(1'b1, 1'b0);
      checkOutput("reset_rinc", rinc, 1'b0);
      checkOutput("reset_m_valid", m_valid, 1'b0);
      checkOutput("reset_m_keep", m_keep, 4'h0);
      checkOutput("reset_m_data", m_data, 32'h0);
      checkOutput("reset_busy", busy, 1'b0);
      rrst = 1'b0;
      #1;
      checkOutput("release_rinc", rinc, 1'b1);

      // Streaming 0x11..0x88 with m_ready held high.
      repeat (8) applyStimulus(1'b1, 1'b0);
      checkOutput("stream_src_drained", src_q.size(), 0);
      repeat (3) applyStimulus(1'b1, 1'b0);
      checkOutput("stream_words", word_log.size(), 2);
      if (word_log.size() == 2) begin
         checkOutput("stream_word0", word_log[0], 32'h44332211);
         checkOutput("stream_word1", word_log[1], 32'h88776655);
         checkOutput("stream_keep0", keep_log[0], 4'hF);
         checkOutput("stream_keep1", keep_log[1], 4'hF);
         checkOutput("stream_back_to_back", cyc_log[1] - cyc_log[0], 4);
      end

      // Backpressure with a held word and three entries in the accumulator.
      clear_logs();
      for (int i = 1; i <= 8; i++) src_q.push_back(DSIZE'(i * 17));
      repeat (10) applyStimulus(1'b0, 1'b0);
      checkOutput("bp_rinc_low", rinc, 1'b0);
      checkOutput("bp_held_valid", m_valid, 1'b1);
      checkOutput("bp_held_data", m_data, 32'h44332211);
      checkOutput("bp_fifo_keeps_entry", src_q.size(), 1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("bp_release_rinc", rinc, 1'b1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("bp_next_valid", m_valid, 1'b1);
      checkOutput("bp_next_data", m_data, 32'h88776655);
      checkOutput("bp_first_transfer", (word_log.size() > 0) ? word_log[0] : 32'hDEAD, 32'h44332211);
      repeat (3) applyStimulus(1'b1, 1'b0);

      // Two entries then silence.
      clear_logs();
      src_q.push_back(8'hAA);
      src_q.push_back(8'hBB);
      repeat (19) applyStimulus(1'b1, 1'b0);
      checkOutput("idle_no_early_word", m_valid, 1'b0);
      applyStimulus(1'b1, 1'b0);
`ifdef FIFO_RD_PACK_TIMEOUT_EN
      checkOutput("timeout_valid", m_valid, 1'b1);
      checkOutput("timeout_data", m_data, 32'h0000BBAA);
      checkOutput("timeout_keep", m_keep, 4'h3);
      applyStimulus(1'b1, 1'b0);
      checkOutput("timeout_cnt_zero_busy", busy, 1'b0);
`else
      checkOutput("partial_waits_valid", m_valid, 1'b0);
      checkOutput("partial_waits_busy", busy, 1'b1);
      repeat (20) applyStimulus(1'b1, 1'b0);
      checkOutput("partial_still_busy", busy, 1'b1);
      src_q.push_back(8'hCC);
      src_q.push_back(8'hDD);
      repeat (4) applyStimulus(1'b1, 1'b0);
      checkOutput("partial_completed", (word_log.size() > 0) ? word_log[0] : 32'hDEAD, 32'hDDCCBBAA);
      checkOutput("partial_keep", (keep_log.size() > 0) ? keep_log[0] : 4'h0, 4'hF);
`endif

      // Reset mid-operation with a held word and two buffered entries.
      for (int i = 0; i < 6; i++) src_q.push_back(DSIZE'($urandom_range(255)));
      repeat (8) applyStimulus(1'b0, 1'b0);
      checkOutput("midrst_pre_valid", m_valid, 1'b1);
      rrst = 1'b1;
      mdl_reset();
      src_q.delete();
      #1;
      checkOutput("midrst_m_valid", m_valid, 1'b0);
      checkOutput("midrst_m_data", m_data, 32'h0);
      checkOutput("midrst_m_keep", m_keep, 4'h0);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_rinc", rinc, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      rrst = 1'b0;
      clear_logs();
      for (int i = 1; i <= 4; i++) src_q.push_back(DSIZE'(i));
      repeat (6) applyStimulus(1'b1, 1'b0);
      checkOutput("midrst_fresh_word", (word_log.size() > 0) ? word_log[0] : 32'hDEAD, 32'h04030201);

      // Randomized traffic with occasional long idle gaps.
      for (int c = 0; c < 3000; c++) begin
         if ((c % 300) >= 270) begin
            applyStimulus(1'($urandom_range(3) != 0), 1'b1);
         end else begin
            n = $urandom_range(9);
            if (n < 6 && src_q.size() < 16) src_q.push_back(DSIZE'($urandom));
            applyStimulus(1'($urandom_range(9) < 7), 1'($urandom_range(9) < 2));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
